// File: rtl/snn_pkg.sv
// Shared SNN layer types and widths.
// Used by the MAC sequencer and its neighbours.
package snn_pkg;

  localparam int ACC_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    MAC  = 2'd2,
    CAPT = 2'd3
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the shared MAC of a fully-connected layer.
// Walks neurons and inputs, drives memory addresses and MAC clear.
module mac_seq_ctrl
  import snn_pkg::*;
#(
  parameter int IN_CNT  = 784,
  parameter int NEU_CNT = 32,
  parameter int IN_AW   = 10,
  parameter int NEU_AW  = 5,
  parameter int WT_AW   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IN_AW-1:0]  in_addr,
  output logic [WT_AW-1:0]  wt_addr,
  output logic              mac_clr_n,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  res_acc,
  output logic [NEU_AW-1:0] res_idx,
  output logic              res_vld,
  output logic              busy,
  output logic              done
);

  localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(IN_CNT - 1);
  localparam logic [IN_AW-1:0]  K_PEN  = IN_AW'(IN_CNT - 2);
  localparam logic [NEU_AW-1:0] N_LAST = NEU_AW'(NEU_CNT - 1);

  mac_seq_state_t r_state;
  mac_seq_state_t w_nxt;

  logic [IN_AW-1:0]  r_k;
  logic [NEU_AW-1:0] r_n;
  logic [WT_AW-1:0]  r_wt;
  logic [ACC_W-1:0]  r_res_acc;
  logic [NEU_AW-1:0] r_res_idx;
  logic              r_res_vld;
  logic              r_done;

  logic w_k_last;
  logic w_n_last;

  assign w_k_last = (r_k == K_LAST);
  assign w_n_last = (r_n == N_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_nxt = CLR;
      CLR:     w_nxt = MAC;
      MAC:     if (w_k_last) w_nxt = CAPT;
      CAPT:    w_nxt = w_n_last ? IDLE : CLR;
      default: w_nxt = IDLE;
    endcase
  end

  // wt_addr leads the data by one cycle, so it steps in CLR and
  // CAPT as well and stops one input early inside MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k  <= '0;
      r_n  <= '0;
      r_wt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_k  <= '0;
          r_n  <= '0;
          r_wt <= '0;
        end
        CLR: begin
          r_k  <= '0;
          r_wt <= r_wt + 1'b1;
        end
        MAC: begin
          r_k <= r_k + 1'b1;
          if (r_k < K_PEN) r_wt <= r_wt + 1'b1;
        end
        CAPT: begin
          if (w_n_last) begin
            r_n  <= '0;
            r_wt <= '0;
          end else begin
            r_n  <= r_n + 1'b1;
            r_wt <= r_wt + 1'b1;
          end
        end
        default: begin
          r_k  <= '0;
          r_n  <= '0;
          r_wt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_acc <= '0;
      r_res_idx <= '0;
      r_res_vld <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;
      r_done    <= 1'b0;
      if (r_state == CAPT) begin
        r_res_acc <= acc;
        r_res_idx <= r_n;
        r_res_vld <= 1'b1;
        r_done    <= w_n_last;
      end
    end
  end

  always_comb begin
    in_addr = '0;
    unique case (r_state)
      MAC:     in_addr = w_k_last ? r_k : r_k + 1'b1;
      CAPT:    in_addr = K_LAST;
      default: in_addr = '0;
    endcase
  end

  assign wt_addr   = r_wt;
  assign mac_clr_n = (r_state == MAC);
  assign busy      = (r_state != IDLE);
  assign res_acc   = r_res_acc;
  assign res_idx   = r_res_idx;
  assign res_vld   = r_res_vld;
  assign done      = r_done;

endmodule
